// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, sample-slot constants, vote helper.
// Pure declarations; no logic, latency or backpressure of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [2:0] SMP_VOTE_A = 3'd3;
  localparam logic [2:0] SMP_VOTE_B = 3'd4;
  localparam logic [2:0] SMP_VOTE_C = 3'd5;
  localparam logic [2:0] SMP_LAST   = 3'd7;
  localparam int         DATA_BITS  = 8;
  localparam logic [2:0] BIT_LAST   = 3'(DATA_BITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_majority_sampler.sv
// RX pin synchroniser plus 2-of-3 bit vote over sample slots 3/4/5.
// rx_s lags Rx_i by 2 clk; vote is valid combinationally in slot 5; no backpressure.
module rx_majority_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_i,
  input  logic       AcqSig_i,
  input  logic [2:0] smp,
  output logic       rx_s,
  output logic       vote
);

  logic sync1_q, sync2_q;
  logic va_q, va_d;
  logic vb_q, vb_d;

  always_comb begin
    va_d = va_q;
    vb_d = vb_q;
    if (AcqSig_i && (smp == SMP_VOTE_A)) va_d = sync2_q;
    if (AcqSig_i && (smp == SMP_VOTE_B)) vb_d = sync2_q;
  end

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      va_q    <= 1'b0;
      vb_q    <= 1'b0;
    end else begin
      sync1_q <= Rx_i;
      sync2_q <= sync1_q;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

  assign rx_s = sync2_q;
  assign vote = maj3(va_q, vb_q, sync2_q);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive FSM: 8 strobes/bit, LSB-first 8 data bits, optional parity, stop voted at slot 5.
// Byte and status registered one clk after the stop-vote strobe; no backpressure, host must take each pulse.
module uart_rx_core
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic       Rx_i,
  input  logic       ParityEn_i,
  input  logic       ParityOdd_i,
  output logic [7:0] Data_o,
  output logic       DataValid_o,
  output logic       ParityErr_o,
  output logic       FrameErr_o,
  output logic       Busy_o
);

  rx_state_e            state_q, state_d;
  logic [2:0]           smp_q, smp_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pen_q, pen_d;
  logic                 podd_q, podd_d;
  logic                 perr_pend_q, perr_pend_d;
  logic [7:0]           data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;
  logic                 vote;

  rx_majority_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .Rx_i     (Rx_i),
    .AcqSig_i (AcqSig_i),
    .smp      (smp_q),
    .rx_s     (rx_s),
    .vote     (vote)
  );

  always_comb begin
    state_d     = state_q;
    smp_d       = smp_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    pen_d       = pen_q;
    podd_d      = podd_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    vld_d       = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    if (AcqSig_i) begin
      smp_d = smp_q + 3'd1;
      unique case (state_q)
        ST_IDLE: begin
          smp_d = 3'd0;
          // The detecting strobe is slot 0 of the start bit.
          if (!rx_s) begin
            state_d = ST_START;
            smp_d   = 3'd1;
            pen_d   = ParityEn_i;
            podd_d  = ParityOdd_i;
          end
        end
        ST_START: begin
          if ((smp_q == SMP_VOTE_C) && vote) begin
            state_d = ST_IDLE;
            smp_d   = 3'd0;
          end else if (smp_q == SMP_LAST) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end
        end
        ST_DATA: begin
          if (smp_q == SMP_VOTE_C) shift_d[idx_q] = vote;
          if (smp_q == SMP_LAST) begin
            if (idx_q == BIT_LAST) state_d = pen_q ? ST_PARITY : ST_STOP;
            else                   idx_d   = idx_q + 3'd1;
          end
        end
        ST_PARITY: begin
          if (smp_q == SMP_VOTE_C) perr_pend_d = ((^shift_q) ^ vote) != podd_q;
          if (smp_q == SMP_LAST)   state_d     = ST_STOP;
        end
        ST_STOP: begin
          // Leave mid-stop so a following start edge is never missed.
          if (smp_q == SMP_VOTE_C) begin
            data_d  = shift_q;
            ferr_d  = ~vote;
            perr_d  = pen_q & perr_pend_q;
            vld_d   = 1'b1;
            state_d = ST_IDLE;
            smp_d   = 3'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          smp_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      smp_q       <= 3'd0;
      idx_q       <= 3'd0;
      shift_q     <= '0;
      pen_q       <= 1'b0;
      podd_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      data_q      <= 8'h00;
      vld_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      pen_q       <= pen_d;
      podd_q      <= podd_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign Data_o      = data_q;
  assign DataValid_o = vld_q;
  assign ParityErr_o = perr_q;
  assign FrameErr_o  = ferr_q;
  assign Busy_o      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive engine for the self-defined UART core, placed directly downstream of the baud-rate generator. It consumes the generator's 8×-oversampling acquisition pulse (`AcqSig_o`) and the raw RX pin. It majority-votes each bit, deserialises LSB-first 8-bit frames with optional parity, and hands each byte to the host side with parity and framing status. The baud-rate generator's compensation scheme only stretches or shrinks acquisition periods, so this block always counts exactly 8 acquisition pulses per bit.

## Interface
- No parameters; frame width fixed at 1 start, 8 data, optional 1 parity, 1 stop.
- `clk`  in  1  system clock, ≥40 MHz
- `rst`  in  1  asynchronous, active-low reset; released synchronously to `clk`
- `AcqSig_i`  in  1  acquisition strobe, one-`clk` pulse, nominally 8 per bit time
- `Rx_i`  in  1  asynchronous serial line, idle high
- `ParityEn_i`  in  1  1 = parity bit present
- `ParityOdd_i`  in  1  1 = odd parity, 0 = even
- `Data_o`  out  8  last received byte
- `DataValid_o`  out  1  one-`clk` pulse when `Data_o`, `ParityErr_o` and `FrameErr_o` update
- `ParityErr_o`  out  1  parity mismatch on last byte; 0 when parity disabled
- `FrameErr_o`  out  1  stop bit voted 0 on last byte
- `Busy_o`  out  1  high whenever the state machine is not IDLE

## Operation
- `Rx_i` passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised value `rx_s`.
- State advances only on `clk` edges where `AcqSig_i` = 1. A 3-bit sample counter `smp` runs 0..7 within each bit.
- Majority vote per bit: capture `rx_s` at `smp` = 3, 4 and 5. The voted bit is resolved at `smp` = 5 as (≥2 ones).
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** when the strobe is present and `rx_s` = 0:
  - go to START with `smp` = 1;
  - latch `ParityEn_i` and `ParityOdd_i` into internal registers, held for the whole frame.
- **START:** at `smp` = 5, if the vote is 1 (false start/glitch), return to IDLE immediately with no output change. Otherwise, at `smp` = 7, go to DATA with bit index 0.
- **DATA:**
  - the voted bit shifts into bit [index] (LSB first);
  - after index 7 ends (`smp` = 7), go to PARITY if latched parity is enabled, else STOP.
- **PARITY:** voted bit p. Error when XOR(data, p) ≠ latched odd flag (even: total ones even; odd: total ones odd). At `smp` = 7, go to STOP.
- **STOP:** at `smp` = 5, after the vote:
  - load `Data_o`;
  - set `FrameErr_o` = ~vote and set `ParityErr_o`;
  - pulse `DataValid_o`;
  - return to IDLE.
  - Leaving at mid-stop lets the next start edge be caught even with a short stop bit.
- Bytes with a framing error are still delivered, with `FrameErr_o` = 1.
- `smp` wraps 7→0 at each bit boundary. The bit index is 3 bits and needs no wrap beyond 7.

## Timing
- Reset values: `Data_o` = 0x00, `DataValid_o` = 0, `ParityErr_o` = 0, `FrameErr_o` = 0, `Busy_o` = 0, state = IDLE, `smp` = 0, synchroniser = 11.
- Asserting `rst` mid-frame aborts it: no `DataValid_o`, and all outputs return to reset values.
- Start detection latency: the falling edge is visible after 2 `clk` (synchroniser), then acted on at the next `AcqSig_i`.
- `DataValid_o`, `Data_o` and both error flags are registered. They update in the same `clk` that `AcqSig_i` (STOP, `smp` = 5) is sampled, and are visible the cycle after.
- `ParityErr_o` and `FrameErr_o` hold until the next `DataValid_o`.
- `Busy_o` rises the cycle after start detection and falls together with the `DataValid_o` pulse.
- `ParityEn_i` / `ParityOdd_i` changes mid-frame have no effect until the next start.
- `AcqSig_i` held high for consecutive cycles counts one sample per cycle; this is illegal upstream and has no protection.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, 3-bit);
  - constants `SMP_VOTE_A` = 3, `SMP_VOTE_B` = 4, `SMP_VOTE_C` = 5, `SMP_LAST` = 7, `DATA_BITS` = 8.
- One sub-module, `rx_majority_sampler`:
  - contains the synchroniser, the three vote captures and the 2-of-3 logic;
  - inputs `clk`, `rst`, `Rx_i`, `AcqSig_i`, `smp`;
  - outputs `rx_s`, `vote`.
- The FSM, shift register and parity accumulator stay in `uart_rx_core`.

## Test plan
- **Nominal byte:** parity off, send 0xA5 at 8 strobes/bit, stop = 1 → exactly one `DataValid_o` pulse, `Data_o` = 0xA5, both error flags 0, `Busy_o` low afterwards.
- **Even parity:** `ParityEn_i` = 1, `ParityOdd_i` = 0, send 0x07 with p = 1 → `ParityErr_o` = 0. Repeat with p = 0 → `ParityErr_o` = 1, `Data_o` = 0x07.
- **Glitch rejection:**
  - `Rx_i` low for 2 strobes only → false start returns to IDLE, no `DataValid_o`;
  - a single inverted sample at `smp` = 4 inside a data bit → the byte is still correct.
- **Framing error:** send 0x3C with stop = 0 → `FrameErr_o` = 1, `Data_o` = 0x3C. The next clean byte 0x11 clears `FrameErr_o`.
- **Back-to-back frames:** 0x55 then 0xFF with no idle between, and stop bits only 6 strobes long → both bytes received in order.
- **Reset abort:** assert `rst` during data bit 3, then release and send 0x81 → no pulse for the aborted frame, and 0x81 is received cleanly.
